binary_to_bcd_display: RTL and testbench

//  Sequential double-dabble converter feeding the four-digit 7-seg scan driver.

---
 rtl/binary_to_bcd_display_pkg.sv | 12 +
 rtl/binary_to_bcd_display_nibble_adjust.sv | 11 +
 rtl/binary_to_bcd_display.sv | 105 ++++++++++
 tb/tb_binary_to_bcd_display.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/binary_to_bcd_display_pkg.sv
// rtl/binary_to_bcd_display_pkg.sv - shared constants for the binary to BCD display converter
package binary_to_bcd_display_pkg;

  localparam logic [0:0]  ST_IDLE        = 1'b0;
  localparam logic [0:0]  ST_SHIFT       = 1'b1;

  localparam int unsigned BCD_MAX        = 9999;
  localparam logic [3:0]  DIGIT_ERROR    = 4'hE;
  localparam logic [3:0]  BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0]  BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/binary_to_bcd_display_nibble_adjust.sv
// rtl/binary_to_bcd_display_nibble_adjust.sv - double-dabble add-3 correction for one BCD nibble
module bcd_nibble_adjust
  import binary_to_bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= BCD_ADJ_THRESH) ? nibble + BCD_ADJ_ADD : nibble;

endmodule

// File: rtl/binary_to_bcd_display.sv
// rtl/binary_to_bcd_display.sv - sequential double-dabble converter with held outputs for the 7-seg scan driver
module binary_to_bcd_display
  import binary_to_bcd_display_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_value,
  input  logic [3:0]       i_dp,
  output logic             o_ready,
  output logic             o_done,
  output logic [3:0]       o_data3,
  output logic [3:0]       o_data2,
  output logic [3:0]       o_data1,
  output logic [3:0]       o_data0,
  output logic             o_dp3,
  output logic             o_dp2,
  output logic             o_dp1,
  output logic             o_dp0,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH);

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] bin;
  logic [15:0]      bcd;
  logic [15:0]      adj;
  logic [3:0]       dp_hold;
  logic             ovf_hold;
  logic [15:0]      next_bcd;
  logic [WIDTH-1:0] next_bin;
  logic             accept;
  logic             in_ovf;

  for (genvar n = 0; n < 4; n++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nibble   (bcd[4*n +: 4]),
      .adjusted (adj[4*n +: 4])
    );
  end

  // The thousands nibble may carry out on overflowing inputs; that bit is dropped.
  assign next_bcd = 16'({adj, bin[WIDTH-1]});
  assign next_bin = {bin[WIDTH-2:0], 1'b0};
  assign o_ready  = (state == ST_IDLE);
  assign accept   = i_valid && o_ready;
  assign in_ovf   = (32'(i_value) > BCD_MAX);

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bin        <= '0;
      bcd        <= '0;
      dp_hold    <= '0;
      ovf_hold   <= 1'b0;
      o_done     <= 1'b0;
      o_data3    <= '0;
      o_data2    <= '0;
      o_data1    <= '0;
      o_data0    <= '0;
      o_dp3      <= 1'b0;
      o_dp2      <= 1'b0;
      o_dp1      <= 1'b0;
      o_dp0      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          state    <= ST_SHIFT;
          bin      <= i_value;
          bcd      <= '0;
          dp_hold  <= i_dp;
          ovf_hold <= in_ovf;
          cnt      <= CW'(WIDTH - 1);
        end
      end else begin
        bin <= next_bin;
        bcd <= next_bcd;
        if (cnt == '0) begin
          // Final shift: publish all outputs together so the scan driver never sees a mix.
          state      <= ST_IDLE;
          o_done     <= 1'b1;
          o_data3    <= ovf_hold ? DIGIT_ERROR : next_bcd[15:12];
          o_data2    <= ovf_hold ? DIGIT_ERROR : next_bcd[11:8];
          o_data1    <= ovf_hold ? DIGIT_ERROR : next_bcd[7:4];
          o_data0    <= ovf_hold ? DIGIT_ERROR : next_bcd[3:0];
          o_dp3      <= dp_hold[3];
          o_dp2      <= dp_hold[2];
          o_dp1      <= dp_hold[1];
          o_dp0      <= dp_hold[0];
          o_overflow <= ovf_hold;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_display.sv
// tb/tb_binary_to_bcd_display.sv - randomized self-checking bench for binary_to_bcd_display
module tb_binary_to_bcd_display;

  localparam int WIDTH = 14;

  logic             clk;
  logic             rst_x;
  logic             i_valid;
  logic [WIDTH-1:0] i_value;
  logic [3:0]       i_dp;
  logic             o_ready;
  logic             o_done;
  logic [3:0]       o_data3, o_data2, o_data1, o_data0;
  logic             o_dp3, o_dp2, o_dp1, o_dp0;
  logic             o_overflow;

  int checks = 0;
  int errors = 0;

  binary_to_bcd_display #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .i_valid    (i_valid),
    .i_value    (i_value),
    .i_dp       (i_dp),
    .o_ready    (o_ready),
    .o_done     (o_done),
    .o_data3    (o_data3),
    .o_data2    (o_data2),
    .o_data1    (o_data1),
    .o_data0    (o_data0),
    .o_dp3      (o_dp3),
    .o_dp2      (o_dp2),
    .o_dp1      (o_dp1),
    .o_dp0      (o_dp0),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by plain division, "EEEE" above 9999.
  function automatic int model_digits(input int value);
    if (value > 9999) return 'hEEEE;
    return ((value / 1000) % 10) * 4096 + ((value / 100) % 10) * 256 +
           ((value / 10) % 10) * 16 + (value % 10);
  endfunction

  function automatic int shown_digits();
    return {o_data3, o_data2, o_data1, o_data0};
  endfunction

  function automatic int shown_dp();
    return {o_dp3, o_dp2, o_dp1, o_dp0};
  endfunction

  task automatic run_conv(input int value, input logic [3:0] dp, input bit interfere);
    int cyc;
    int low;
    i_valid = 1'b1;
    i_value = WIDTH'(value);
    i_dp    = dp;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_value = WIDTH'($urandom);
    i_dp    = 4'($urandom);
    cyc = 0;
    low = 0;
    while (!o_done && cyc < 40) begin
      if (!o_ready) low++;
      if (interfere && cyc == 3) begin
        i_valid = 1'b1;
        i_value = WIDTH'(42);
      end
      if (interfere && cyc == 10) i_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", cyc, WIDTH);
    check_eq("ready_low_cycles", low, WIDTH);
    check_eq("ready_at_done", int'(o_ready), 1);
    check_eq($sformatf("digits_%0d", value), shown_digits(), model_digits(value));
    check_eq($sformatf("dp_%0d", value), shown_dp(), int'(dp));
    check_eq($sformatf("ovf_%0d", value), int'(o_overflow), int'(value > 9999));
    i_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("done_single_pulse", int'(o_done), 0);
    check_eq("digits_held", shown_digits(), model_digits(value));
  endtask

  initial begin
    int pulses;
    int gap;
    int v;
    rst_x   = 1'b0;
    i_valid = 1'b0;
    i_value = '0;
    i_dp    = '0;
    repeat (3) @(posedge clk);
    #1 rst_x = 1'b1;

    check_eq("rst_ready", int'(o_ready), 1);
    check_eq("rst_done", int'(o_done), 0);
    check_eq("rst_digits", shown_digits(), 0);
    check_eq("rst_dp", shown_dp(), 0);
    check_eq("rst_ovf", int'(o_overflow), 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done) pulses++;
    end
    check_eq("idle_no_done", pulses, 0);
    check_eq("idle_digits", shown_digits(), 0);

    run_conv(1234, 4'b0100, 1'b0);
    run_conv(0, 4'b0000, 1'b0);
    run_conv(9999, 4'b1111, 1'b0);
    run_conv(10000, 4'b0001, 1'b0);
    run_conv(16383, 4'b1000, 1'b0);
    run_conv(5678, 4'b0010, 1'b1);

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(16383, 0));
      run_conv(v, 4'($urandom), 1'b0);
    end

    // Back-to-back: i_valid held high, second request taken while o_done is shown.
    i_valid = 1'b1;
    i_value = WIDTH'(1);
    i_dp    = 4'b0000;
    @(posedge clk); #1;
    i_value = WIDTH'(2);
    gap = 0;
    while (!o_done && gap < 40) begin
      @(posedge clk); #1;
      gap++;
    end
    check_eq("b2b_first_latency", gap, WIDTH);
    check_eq("b2b_first_digits", shown_digits(), 'h0001);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) begin
        i_valid = 1'b0;
        check_eq("b2b_accepted", int'(o_ready), 0);
        check_eq("b2b_first_held", shown_digits(), 'h0001);
      end
    end while (!o_done && gap < 40);
    check_eq("b2b_gap", gap, WIDTH + 1);
    check_eq("b2b_second_digits", shown_digits(), 'h0002);
    @(posedge clk); #1;

    // Reset in the middle of a conversion clears everything at once.
    run_conv(4321, 4'b1010, 1'b0);
    i_valid = 1'b1;
    i_value = WIDTH'(8765);
    i_dp    = 4'b1111;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_x = 1'b0;
    #1;
    check_eq("mid_rst_digits", shown_digits(), 0);
    check_eq("mid_rst_dp", shown_dp(), 0);
    check_eq("mid_rst_ready", int'(o_ready), 1);
    check_eq("mid_rst_done", int'(o_done), 0);
    check_eq("mid_rst_ovf", int'(o_overflow), 0);
    @(posedge clk); #1 rst_x = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done) pulses++;
    end
    check_eq("post_rst_no_done", pulses, 0);
    check_eq("post_rst_digits", shown_digits(), 0);
    check_eq("post_rst_ready", int'(o_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
